// File: rtl/rf_pkg.sv
// Shared constants and write-decode helper for the multi-port register file.
// Default-width constants used by reg_file_mp and rf_scoreboard.
package rf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  // Bit n of the one-hot clear mask produced by one write port; address 0 never decodes.
  function automatic logic rf_clr_mask_bit(input logic we, input int unsigned wa,
                                           input int unsigned n);
    return we && (wa == n) && (wa != 32'd0);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-producer scoreboard: issue sets a register's busy bit, a write clears it,
// and a same-cycle issue wins over the clear.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we0,
  input  logic [ADDR_W-1:0]    wa0,
  input  logic                 we1,
  input  logic [ADDR_W-1:0]    wa1,
  input  logic                 iss_en,
  input  logic [ADDR_W-1:0]    iss_addr,
  output logic [2**ADDR_W-1:0] busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [DEPTH-1:0] clr_s;
  logic [DEPTH-1:0] set_s;

  // Decode set/clear masks and apply set-over-clear priority.
  always_comb begin
    clr_s = '0;
    set_s = '0;
    for (int unsigned n = 1; n < DEPTH; n++) begin
      clr_s[n] = rf_clr_mask_bit(we0, 32'(wa0), n) | rf_clr_mask_bit(we1, 32'(wa1), n);
      set_s[n] = iss_en && (32'(iss_addr) == n);
    end
    if (reset) begin
      busy_d = '0;
    end else begin
      busy_d = (busy_q & ~clr_s) | set_s;
    end
    busy_d[0] = 1'b0;
  end

  // Busy state register.
  always_ff @(posedge clk) begin
    busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Two-write, NUM_RD-read register file with r0 hardwired to zero and a busy scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write data (and drop rbusy) to matching reads.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [2**ADDR_W-1:0]     busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0] ra_s  [NUM_RD];

  // Next array state: reset clears, port 1 wins on a shared address, r0 stays zero.
  always_comb begin
    for (int n = 0; n < DEPTH; n++) begin
      if (reset) begin
        mem_d[n] = '0;
      end else if (we1 && (wa1 == ADDR_W'(n))) begin
        mem_d[n] = wd1;
      end else if (we0 && (wa0 == ADDR_W'(n))) begin
        mem_d[n] = wd0;
      end else begin
        mem_d[n] = mem_q[n];
      end
    end
    mem_d[0] = '0;
  end

  // Register array.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Unpack the read address bus.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      ra_s[k] = ra[k*ADDR_W +: ADDR_W];
    end
  end

  // Combinational read muxes with optional same-cycle write forwarding.
  always_comb begin
    rd    = '0;
    rbusy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
`ifdef RF_BYPASS_EN
      if ((ra_s[k] != '0) && we1 && (wa1 == ra_s[k])) begin
        rd[k*DATA_W +: DATA_W] = wd1;
        rbusy[k]               = 1'b0;
      end else if ((ra_s[k] != '0) && we0 && (wa0 == ra_s[k])) begin
        rd[k*DATA_W +: DATA_W] = wd0;
        rbusy[k]               = 1'b0;
      end else begin
        rd[k*DATA_W +: DATA_W] = mem_q[ra_s[k]];
        rbusy[k]               = busy_vec[ra_s[k]];
      end
`else
      rd[k*DATA_W +: DATA_W] = mem_q[ra_s[k]];
      rbusy[k]               = busy_vec[ra_s[k]];
`endif
    end
  end

  rf_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .we0     (we0),
    .wa0     (wa0),
    .we1     (we1),
    .wa1     (wa1),
    .iss_en  (iss_en),
    .iss_addr(iss_addr),
    .busy_vec(busy_vec)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed table-driven bench for reg_file_mp (default 32x32, two read ports).
module tb_reg_file_mp;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        we0, we1, iss_en;
  logic [4:0]  wa0, wa1, iss_addr;
  logic [31:0] wd0, wd1;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rbusy;
  logic [31:0] busy_vec;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp_rd0;
    logic [31:0] exp_rd1;
    logic [1:0]  exp_rbusy;
    logic [31:0] exp_busy;
  } vec_t;

  vec_t vecs[$];

  reg_file_mp dut (
    .clk     (clk),
    .reset   (reset),
    .we0     (we0),
    .wa0     (wa0),
    .wd0     (wd0),
    .we1     (we1),
    .wa1     (wa1),
    .wd1     (wd1),
    .ra      (ra),
    .rd      (rd),
    .rbusy   (rbusy),
    .iss_en  (iss_en),
    .iss_addr(iss_addr),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic add(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                     input logic e1, input logic [4:0] a1, input logic [31:0] d1,
                     input logic ie, input logic [4:0] ia,
                     input logic [4:0] r0, input logic [4:0] r1,
                     input logic [31:0] x0, input logic [31:0] x1,
                     input logic [1:0] xb, input logic [31:0] xv);
    vec_t v;
    v.we0 = e0; v.wa0 = a0; v.wd0 = d0;
    v.we1 = e1; v.wa1 = a1; v.wd1 = d1;
    v.iss_en = ie; v.iss_addr = ia;
    v.ra0 = r0; v.ra1 = r1;
    v.exp_rd0 = x0; v.exp_rd1 = x1; v.exp_rbusy = xb; v.exp_busy = xv;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1; we0 = 1'b0; we1 = 1'b0; iss_en = 1'b0;
    wa0 = 5'd0; wa1 = 5'd0; wd0 = 32'd0; wd1 = 32'd0; iss_addr = 5'd0; ra = 10'd0;

    // we0 wa0 wd0 | we1 wa1 wd1 | iss | ra0 ra1 | rd0 rd1 rbusy busy_vec
    add(0, 0, 0,            0, 0, 0,       0, 0, 3, 0, 32'h0, 32'h0, 2'b00, 32'h0);
    add(1, 5, 32'hDEADBEEF, 0, 0, 0,       0, 0, 5, 0, BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 2'b00, 32'h0);
    add(0, 0, 0,            0, 0, 0,       0, 0, 5, 0, 32'hDEADBEEF, 32'h0, 2'b00, 32'h0);
    add(1, 7, 32'h11,       1, 7, 32'h22,  0, 0, 7, 5, BYP ? 32'h22 : 32'h0, 32'hDEADBEEF, 2'b00, 32'h0);
    add(0, 0, 0,            0, 0, 0,       0, 0, 7, 7, 32'h22, 32'h22, 2'b00, 32'h0);
    add(0, 0, 0,            0, 0, 0,       1, 9, 9, 0, 32'h0, 32'h0, 2'b00, 32'h0);
    add(0, 0, 0,            0, 0, 0,       0, 0, 9, 9, 32'h0, 32'h0, 2'b11, 32'h200);
    add(0, 0, 0,            1, 9, 32'h5A,  0, 0, 9, 7, BYP ? 32'h5A : 32'h0, 32'h22,
        BYP ? 2'b00 : 2'b01, 32'h200);
    add(0, 0, 0,            0, 0, 0,       0, 0, 9, 7, 32'h5A, 32'h22, 2'b00, 32'h0);
    add(1, 4, 32'h33,       0, 0, 0,       1, 4, 4, 0, BYP ? 32'h33 : 32'h0, 32'h0, 2'b00, 32'h0);
    add(1, 0, 32'hFFFF,     0, 0, 0,       0, 0, 0, 4, 32'h0, 32'h33, 2'b10, 32'h10);
    add(0, 0, 0,            0, 0, 0,       1, 9, 0, 4, 32'h0, 32'h33, 2'b10, 32'h10);
    add(0, 0, 0,            1, 0, 32'h77,  1, 0, 9, 4, 32'h5A, 32'h33, 2'b11, 32'h210);
    add(1, 10, 32'hA,       1, 11, 32'hB,  0, 0, 0, 0, 32'h0, 32'h0, 2'b00, 32'h210);
    add(0, 0, 0,            0, 0, 0,       0, 0, 10, 11, 32'hA, 32'hB, 2'b00, 32'h210);

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = 1'b0;
      we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
      we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
      iss_en = vecs[i].iss_en; iss_addr = vecs[i].iss_addr;
      ra = {vecs[i].ra1, vecs[i].ra0};
      #1;
      chk($sformatf("v%0d rd0", i), rd[31:0], vecs[i].exp_rd0);
      chk($sformatf("v%0d rd1", i), rd[63:32], vecs[i].exp_rd1);
      chk($sformatf("v%0d rbusy", i), {30'd0, rbusy}, {30'd0, vecs[i].exp_rbusy});
      chk($sformatf("v%0d busy_vec", i), busy_vec, vecs[i].exp_busy);
    end

    // Reset while busy_vec=0x210 and reg4=0x33; the same-cycle write and issue are dropped.
    @(negedge clk);
    reset = 1'b1;
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h99;
    we1 = 1'b0; wa1 = 5'd0; wd1 = 32'd0;
    iss_en = 1'b1; iss_addr = 5'd3;
    ra = {5'd3, 5'd4};
    @(negedge clk);
    reset = 1'b0;
    we0 = 1'b0; iss_en = 1'b0;
    #1;
    chk("rst busy_vec", busy_vec, 32'h0);
    chk("rst reg4", rd[31:0], 32'h0);
    chk("rst reg3", rd[63:32], 32'h0);
    chk("rst rbusy", {30'd0, rbusy}, 32'h0);

    // The discarded issue must not appear one cycle later either.
    @(negedge clk);
    #1;
    chk("post-rst busy_vec", busy_vec, 32'h0);
    chk("post-rst reg3", rd[63:32], 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter ADDR_W, default 5, register address width; depth is 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2, number of read ports, legal range 1..4.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 we0  in  1  write port 0 enable.
REQ-007 wa0  in  ADDR_W  write port 0 address.
REQ-008 wd0  in  DATA_W  write port 0 data.
REQ-009 we1, wa1, wd1  in  1/ADDR_W/DATA_W  write port 1, same meaning as port 0.
REQ-010 ra  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-011 rd  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W].
REQ-012 rbusy  out  NUM_RD  per-read-port flag, set when the addressed register has a pending (issued, not yet written) producer.
REQ-013 iss_en  in  1  issue strobe: marks register iss_addr as pending.
REQ-014 iss_addr  in  ADDR_W  register claimed by the issuing instruction.
REQ-015 busy_vec  out  2**ADDR_W  scoreboard state, bit n = register n pending.

Function
REQ-016 Register 0 SHALL read as 0 on every port; writes and issues to address 0 SHALL be ignored, and busy_vec[0] SHALL stay 0.
REQ-017 Reads SHALL be combinational from current array state plus bypass (REQ-020); zero-cycle latency.
REQ-018 Writes SHALL take effect at the clock edge on which weN=1; data is visible through the array the following cycle.
REQ-019 When we0=we1=1 and wa0=wa1≠0, port 1 SHALL win; the register holds wd1.
REQ-020 Bypass (RF_BYPASS_EN defined): if ra[k]≠0 matches an enabled write address in the same cycle, rd[k] SHALL return that write data (port 1 over port 0).
REQ-021 Scoreboard: iss_en=1 with iss_addr≠0 SHALL set busy_vec[iss_addr] at the edge.
REQ-022 A write to address n≠0 on either port SHALL clear busy_vec[n] at the edge.
REQ-023 Issue and write to the same register in the same cycle: set SHALL win (busy stays 1; a new producer is pending).
REQ-024 rbusy[k] SHALL equal busy_vec[ra[k]], except that it SHALL read 0 when RF_BYPASS_EN is defined and the same-cycle write bypass of REQ-020 supplies the data.
REQ-025 Writes to a register not marked busy SHALL still update the array; no error flag.

Reset
REQ-026 On reset=1 at an edge, all registers SHALL become 0 and busy_vec SHALL become all 0; writes and issues in that cycle are discarded.
REQ-027 After reset, rd SHALL be 0 and rbusy SHALL be 0 on all ports; no initial-block initialisation is relied on.

Configuration
REQ-028 Macro RF_BYPASS_EN defined: same-cycle write-to-read forwarding per REQ-020/REQ-024.
REQ-029 Macro RF_BYPASS_EN undefined: rd[k] SHALL come from the array only, and rbusy[k] SHALL be the raw busy_vec bit; the consumer stalls one cycle more.

Structure
REQ-030 Shared package rf_pkg SHALL hold the default DATA_W/ADDR_W/NUM_RD constants and a function that decodes a write into a one-hot clear mask.
REQ-031 Sub-module rf_scoreboard SHALL own busy_vec (set/clear/priority logic); the data array and read muxes stay in reg_file_mp.

Verification
REQ-032 Reset, then ra port0=3, port1=0 -> rd0=0, rd1=0, rbusy=0, busy_vec=0.
REQ-033 we0=1 wa0=5 wd0=0xDEADBEEF, next cycle ra0=5 -> rd0=0xDEADBEEF; with RF_BYPASS_EN the value appears in the write cycle itself.
REQ-034 we0=1 wa0=7 wd0=0x11, we1=1 wa1=7 wd1=0x22 same cycle -> reg7=0x22.
REQ-035 iss_en=1 iss_addr=9, then ra0=9 -> rbusy[0]=1; we1=1 wa1=9 wd1=0x5A -> busy_vec[9]=0 next cycle, rd0=0x5A.
REQ-036 iss_en=1 iss_addr=4 and we0=1 wa0=4 same cycle -> busy_vec[4]=1 after the edge; we0=1 wa0=0 wd0=0xFFFF -> rd for ra=0 stays 0.
REQ-037 Reset asserted while busy_vec=0x0000_0210 and reg4=0x33 -> next cycle busy_vec=0, reg4 reads 0.
